sync_sram_2p: RTL and testbench
===============================

Name: sync_sram_2p

Overview:
Parametrised two-port (1 write, 1 read) synchronous SRAM; next generation of the team's 8-bit x 16-word single-port sync SRAM, for memory-system design exercises.
- Adds byte-write enables, selectable read latency, write-first read-during-write bypass, a read-valid strobe and a post-reset zero-initialisation sweep.
- Everything on the rising edge of CK; no negedge logic and no tri-state output.

Parameters:
DATA_BIT, 32, word width in bits; must be a multiple of 8.
ADDRESS_BIT, 4, address width; depth = 2**ADDRESS_BIT words.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
INIT_ZERO, 1, 1 = zero every word after each reset; 0 = no sweep, contents kept across reset.

Ports:
CK  input  1  clock; all state updates on posedge.
RST  input  1  reset, asynchronous, active-high.
WEN  input  1  write request.
WADDR  input  ADDRESS_BIT  write address.
WDATA  input  DATA_BIT  write data.
WBE  input  DATA_BIT/8  byte enables; bit i covers WDATA[8i+7:8i].
RCS  input  1  read request.
RADDR  input  ADDRESS_BIT  read address.
RDATA  output  DATA_BIT  read data, registered.
RVALID  output  1  RDATA valid this cycle; one pulse per accepted read.
BUSY  output  1  init sweep in progress; requests ignored.

Behaviour:
- Reset (async, while RST=1):
  - RDATA=0, RVALID=0, read pipeline cleared.
  - State forced to ST_INIT with clear counter=0 if INIT_ZERO=1, else ST_RUN.
  - BUSY=INIT_ZERO.
  - Memory array is never reset asynchronously.
- ST_INIT:
  - Each posedge writes 0 to mem[counter], then counter+1.
  - The posedge that writes address DEPTH-1 moves the FSM to ST_RUN and clears BUSY: BUSY is high for exactly DEPTH posedges after RST deasserts.
  - While BUSY=1: WEN/RCS ignored, no user writes, no RVALID.
- ST_RUN write: posedge with WEN=1 updates byte i of mem[WADDR] for each WBE[i]=1; other bytes unchanged. WBE=0 means no change.
- ST_RUN read: posedge with RCS=1 is accepted.
  - RD_LAT=1: RDATA/RVALID appear in the next cycle.
  - RD_LAT=2: one more register stage.
  - Fully pipelined; one read per cycle sustained; data returned in request order.
- RDATA holds its last value while RVALID=0. Never Z; the old tri-state behaviour is removed.
- Same-cycle read and write to the same address: write-first. The read returns the merged word: WDATA bytes where WBE=1, old bytes elsewhere. Different addresses are independent.
- Reset mid-operation:
  - In-flight reads are dropped (no RVALID).
  - The init sweep restarts at address 0; a partial sweep is not resumed.
- Power-up contents with INIT_ZERO=0 are undefined (X in simulation).
- Counter width is ADDRESS_BIT. Wrap from DEPTH-1 to 0 only occurs on reset re-entry.

Decomposition:
- Package sram_pkg: BYTE_BIT=8, NBYTE=DATA_BIT/8 function/constant, FSM encoding ST_INIT=1'b0, ST_RUN=1'b1, legal RD_LAT range check.
- Sub-module sync_sram_merge: combinational byte merge (old word, WDATA, WBE → new word).
  - Instanced twice: write path and collision bypass.
- Read pipeline and FSM stay in the top level.

Test Plan:
All scenarios use DATA_BIT=32, ADDRESS_BIT=4, RD_LAT=1, INIT_ZERO=1 unless stated.
1. Init sweep: RST high 3 cycles then low → BUSY=1 for exactly 16 posedges, then 0. Reads of addr 0..15 → 0x00000000, RVALID one cycle each.
2. Byte write: write 0x11223344 WBE=4'hF addr 3, then 0xAABBCCDD WBE=4'b0101 addr 3, read addr 3 → RDATA=0x11BB33DD.
3. Collision: mem[5]=0xDEADBEEF, mem[6]=0x00000066.
   - Same-cycle write 0x01020304 WBE=4'b0011 addr 5 and read addr 5 → RDATA=0xDEAD0304.
   - Same-cycle write addr 5 and read addr 6 → RDATA=0x00000066.
4. Latency (RD_LAT=2): reads addr 0..3 on four consecutive cycles after writing 0x10..0x13 → RVALID high 4 consecutive cycles starting 2 cycles after the first request; data 0x10,0x11,0x12,0x13 in order.
5. Reset mid-sweep and mid-read:
   - Assert RST at counter=7 with a read in flight → RVALID=0, RDATA=0 immediately.
   - After release, BUSY high 16 more cycles.
   - Write 0xFFFFFFFF addr 2 during BUSY → later read of addr 2 → 0x00000000.
6. INIT_ZERO=0: BUSY stays 0. Write 0x5A5A5A5A addr 9, pulse RST one cycle, read addr 9 → 0x5A5A5A5A.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants, FSM encoding and parameter checks for the two-port sync SRAM.
package sram_pkg;

   localparam int BYTE_BIT = 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int nbyte(input int data_bit);
      return data_bit / BYTE_BIT;
   endfunction

   function automatic bit rd_lat_legal(input int rd_lat);
      return (rd_lat == 1) || (rd_lat == 2);
   endfunction

endpackage

// File: rtl/sync_sram_2p_if.sv
// Request/response bundle of the two-port SRAM: one write port, one read port, status.
interface sync_sram_2p_if
   import sram_pkg::*;
#(
   parameter int DATA_BIT    = 32,
   parameter int ADDRESS_BIT = 4
) ();

   localparam int NB = nbyte(DATA_BIT);

   logic                   WEN;
   logic [ADDRESS_BIT-1:0] WADDR;
   logic [DATA_BIT-1:0]    WDATA;
   logic [NB-1:0]          WBE;
   logic                   RCS;
   logic [ADDRESS_BIT-1:0] RADDR;
   logic [DATA_BIT-1:0]    RDATA;
   logic                   RVALID;
   logic                   BUSY;

   modport master (
      output WEN, WADDR, WDATA, WBE, RCS, RADDR,
      input  RDATA, RVALID, BUSY
   );

   modport slave (
      input  WEN, WADDR, WDATA, WBE, RCS, RADDR,
      output RDATA, RVALID, BUSY
   );

endinterface

// File: rtl/sync_sram_merge.sv
// Byte-lane merge: each lane takes the new byte where its enable is set, else keeps the old one.
module sync_sram_merge
   import sram_pkg::*;
#(
   parameter int DATA_BIT = 32
) (
   input  logic [DATA_BIT-1:0]        old_word,
   input  logic [DATA_BIT-1:0]        new_data,
   input  logic [nbyte(DATA_BIT)-1:0] be,
   output logic [DATA_BIT-1:0]        merged
);

   localparam int NB = nbyte(DATA_BIT);

   always_comb begin
      // NOTE: default assignment first so every path drives merged; no latch is inferred.
      merged = old_word;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) merged[i*BYTE_BIT +: BYTE_BIT] = new_data[i*BYTE_BIT +: BYTE_BIT];
      end
   end

endmodule

// File: rtl/sync_sram_2p.sv
// Two-port synchronous SRAM with byte enables, write-first bypass,
// 1- or 2-cycle read latency and an optional post-reset zeroing sweep.
module sync_sram_2p
   import sram_pkg::*;
#(
   parameter int DATA_BIT    = 32,
   parameter int ADDRESS_BIT = 4,
   parameter int RD_LAT      = 1,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic          CK,
   input  logic          RST,
   sync_sram_2p_if.slave bus
);

   localparam int                     DEPTH     = 2 ** ADDRESS_BIT;
   localparam logic [ADDRESS_BIT-1:0] LAST_ADDR = '1;
   localparam state_t                 RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

   if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("sync_sram_2p: RD_LAT must be 1 or 2");
   end
   if ((DATA_BIT % BYTE_BIT) != 0) begin : g_bad_width
      $error("sync_sram_2p: DATA_BIT must be a multiple of 8");
   end

   state_t                 state, state_nxt;
   logic [ADDRESS_BIT-1:0] clr_cnt, clr_cnt_nxt;

   always_ff @(posedge CK or posedge RST) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         state   <= RST_STATE;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // The counter parks on the last address; it only returns to 0 through reset.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         ST_INIT: begin
            if (clr_cnt == LAST_ADDR) state_nxt   = ST_RUN;
            else                      clr_cnt_nxt = clr_cnt + 1'b1;
         end
         default: ;
      endcase
   end

   logic                run, wr_en, rd_acc, hit;
   logic [DATA_BIT-1:0] mem [DEPTH];
   logic [DATA_BIT-1:0] wr_old, wr_word, rd_word, byp_word, rd_fwd;

   assign run    = (state == ST_RUN);
   assign wr_en  = run && bus.WEN;
   assign rd_acc = run && bus.RCS;
   assign wr_old = mem[bus.WADDR];
   assign rd_word = mem[bus.RADDR];
   assign hit    = wr_en && (bus.WADDR == bus.RADDR);
   assign rd_fwd = hit ? byp_word : rd_word;

   sync_sram_merge #(.DATA_BIT(DATA_BIT)) u_wr_merge (
      .old_word (wr_old),
      .new_data (bus.WDATA),
      .be       (bus.WBE),
      .merged   (wr_word)
   );

   sync_sram_merge #(.DATA_BIT(DATA_BIT)) u_byp_merge (
      .old_word (rd_word),
      .new_data (bus.WDATA),
      .be       (bus.WBE),
      .merged   (byp_word)
   );

   // NOTE: the array has no reset; clearing is done by the synchronous sweep so it maps onto SRAM macros.
   always_ff @(posedge CK) begin
      if (!RST) begin
         if (state == ST_INIT) mem[clr_cnt]   <= '0;
         else if (wr_en)       mem[bus.WADDR] <= wr_word;
      end
   end

   logic                rvalid1;
   logic [DATA_BIT-1:0] rdata1;

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         rvalid1 <= 1'b0;
         rdata1  <= '0;
      end else begin
         rvalid1 <= rd_acc;
         if (rd_acc) rdata1 <= rd_fwd;
      end
   end

   // Data registers load only with a valid beat, so RDATA holds between reads.
   if (RD_LAT == 2) begin : g_lat2
      logic                rvalid2;
      logic [DATA_BIT-1:0] rdata2;

      always_ff @(posedge CK or posedge RST) begin
         if (RST) begin
            rvalid2 <= 1'b0;
            rdata2  <= '0;
         end else begin
            rvalid2 <= rvalid1;
            if (rvalid1) rdata2 <= rdata1;
         end
      end

      assign bus.RVALID = rvalid2;
      assign bus.RDATA  = rdata2;
   end else begin : g_lat1
      assign bus.RVALID = rvalid1;
      assign bus.RDATA  = rdata1;
   end

   assign bus.BUSY = (state == ST_INIT);

endmodule

// File: tb/tb_sync_sram_2p.sv
// Self-checking bench: latency-1 and latency-2 SRAMs share stimulus and a reference model;
// a third instance without the init sweep checks retention across reset.
module tb_sync_sram_2p;

   logic CK    = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int busy_cnt = 0;

   logic [31:0] mmem [16];
   logic [31:0] last1 = '0;
   logic [31:0] last2 = '0;

   typedef struct {
      int          due;
      logic [31:0] data;
   } pend_t;
   pend_t q1[$];
   pend_t q2[$];

   typedef struct {
      logic        wen;
      logic [3:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wbe;
      logic        rcs;
      logic [3:0]  raddr;
      logic        exp_rv;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t vt [12];

   sync_sram_2p_if #(.DATA_BIT(32), .ADDRESS_BIT(4)) if0 ();
   sync_sram_2p_if #(.DATA_BIT(32), .ADDRESS_BIT(4)) if1 ();
   sync_sram_2p_if #(.DATA_BIT(32), .ADDRESS_BIT(4)) if2 ();

   sync_sram_2p #(.DATA_BIT(32), .ADDRESS_BIT(4), .RD_LAT(1), .INIT_ZERO(1'b1)) u0 (
      .CK(CK), .RST(rst_a), .bus(if0));
   sync_sram_2p #(.DATA_BIT(32), .ADDRESS_BIT(4), .RD_LAT(2), .INIT_ZERO(1'b1)) u1 (
      .CK(CK), .RST(rst_a), .bus(if1));
   sync_sram_2p #(.DATA_BIT(32), .ADDRESS_BIT(4), .RD_LAT(1), .INIT_ZERO(1'b0)) u2 (
      .CK(CK), .RST(rst_b), .bus(if2));

   always #5 CK = ~CK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] apply_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_w & ~m) | (new_w & m);
   endfunction

   // One clock of shared stimulus on if0/if1, then compare both against the model.
   task automatic step(input logic wen, input logic [3:0] waddr, input logic [31:0] wdata,
                       input logic [3:0] wbe, input logic rcs, input logic [3:0] raddr);
      logic [31:0] rd;
      logic        ev;
      if0.WEN = wen; if0.WADDR = waddr; if0.WDATA = wdata; if0.WBE = wbe;
      if0.RCS = rcs; if0.RADDR = raddr;
      if1.WEN = wen; if1.WADDR = waddr; if1.WDATA = wdata; if1.WBE = wbe;
      if1.RCS = rcs; if1.RADDR = raddr;
      if (busy_cnt > 0) begin
         busy_cnt--;
      end else begin
         if (rcs) begin
            rd = mmem[raddr];
            if (wen && waddr == raddr) rd = apply_bytes(rd, wdata, wbe);
            q1.push_back('{cyc + 1, rd});
            q2.push_back('{cyc + 2, rd});
         end
         if (wen) mmem[waddr] = apply_bytes(mmem[waddr], wdata, wbe);
      end
      @(posedge CK); #1; cyc++;
      ev = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
         ev = 1'b1; last1 = q1[0].data; void'(q1.pop_front());
      end
      check("rvalid_l1", {31'b0, if0.RVALID}, {31'b0, ev});
      check("rdata_l1", if0.RDATA, last1);
      ev = 1'b0;
      if (q2.size() > 0 && q2[0].due == cyc) begin
         ev = 1'b1; last2 = q2[0].data; void'(q2.pop_front());
      end
      check("rvalid_l2", {31'b0, if1.RVALID}, {31'b0, ev});
      check("rdata_l2", if1.RDATA, last2);
      check("busy_l1", {31'b0, if0.BUSY}, {31'b0, busy_cnt > 0});
      check("busy_l2", {31'b0, if1.BUSY}, {31'b0, busy_cnt > 0});
   endtask

   task automatic idle();
      step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
   endtask

   // Assert the shared reset asynchronously, check outputs clear at once, hold n edges, release.
   task automatic reset_a(input int n);
      rst_a = 1'b1;
      #1;
      check("rst_rvalid_l1", {31'b0, if0.RVALID}, 32'd0);
      check("rst_rdata_l1", if0.RDATA, 32'd0);
      check("rst_rvalid_l2", {31'b0, if1.RVALID}, 32'd0);
      check("rst_rdata_l2", if1.RDATA, 32'd0);
      check("rst_busy", {31'b0, if0.BUSY}, 32'd1);
      for (int i = 0; i < 16; i++) mmem[i] = '0;
      q1.delete(); q2.delete();
      last1 = '0; last2 = '0;
      busy_cnt = 16;
      repeat (n) begin @(posedge CK); #1; cyc++; end
      rst_a = 1'b0;
   endtask

   task automatic count_busy(input logic wen_junk, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!if0.BUSY) break;
         step(wen_junk, 4'd2, 32'hFFFF_FFFF, 4'hF, wen_junk, 4'd2);
         n++;
      end
   endtask

   initial begin
      int          n;
      logic [3:0]  wa, ra;
      logic        exp_rv2 [6];
      logic [31:0] exp_d2  [6];

      vt[0]  = '{1'b1, 4'd3,  32'h1122_3344, 4'hF,    1'b0, 4'd0,  1'b0, 32'h0000_0000};
      vt[1]  = '{1'b1, 4'd3,  32'hAABB_CCDD, 4'b0101, 1'b0, 4'd0,  1'b0, 32'h0000_0000};
      vt[2]  = '{1'b0, 4'd0,  32'h0,         4'h0,    1'b1, 4'd3,  1'b1, 32'h11BB_33DD};
      vt[3]  = '{1'b1, 4'd5,  32'hDEAD_BEEF, 4'hF,    1'b0, 4'd0,  1'b0, 32'h11BB_33DD};
      vt[4]  = '{1'b1, 4'd6,  32'h0000_0066, 4'hF,    1'b0, 4'd0,  1'b0, 32'h11BB_33DD};
      vt[5]  = '{1'b1, 4'd5,  32'h0102_0304, 4'b0011, 1'b1, 4'd5,  1'b1, 32'hDEAD_0304};
      vt[6]  = '{1'b1, 4'd5,  32'h9999_9999, 4'hF,    1'b1, 4'd6,  1'b1, 32'h0000_0066};
      vt[7]  = '{1'b0, 4'd0,  32'h0,         4'h0,    1'b1, 4'd5,  1'b1, 32'h9999_9999};
      vt[8]  = '{1'b1, 4'd6,  32'hFFFF_FFFF, 4'h0,    1'b1, 4'd6,  1'b1, 32'h0000_0066};
      vt[9]  = '{1'b0, 4'd0,  32'h0,         4'h0,    1'b0, 4'd0,  1'b0, 32'h0000_0066};
      vt[10] = '{1'b1, 4'd15, 32'hA5A5_A5A5, 4'b1000, 1'b1, 4'd15, 1'b1, 32'hA500_0000};
      vt[11] = '{1'b0, 4'd0,  32'h0,         4'h0,    1'b1, 4'd0,  1'b1, 32'h0000_0000};

      exp_rv2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_d2  = '{32'h0, 32'h10, 32'h11, 32'h12, 32'h13, 32'h13};

      if0.WEN = 0; if0.WADDR = 0; if0.WDATA = 0; if0.WBE = 0; if0.RCS = 0; if0.RADDR = 0;
      if1.WEN = 0; if1.WADDR = 0; if1.WDATA = 0; if1.WBE = 0; if1.RCS = 0; if1.RADDR = 0;
      if2.WEN = 0; if2.WADDR = 0; if2.WDATA = 0; if2.WBE = 0; if2.RCS = 0; if2.RADDR = 0;

      // Power-up reset and init sweep length.
      #2;
      rst_b = 1'b1;
      reset_a(3);
      rst_b = 1'b0;
      count_busy(1'b0, n);
      check("busy_len_init", 32'(n), 32'd16);
      for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a));
      idle();

      // Byte enables and read-during-write collisions.
      for (int i = 0; i < 12; i++) begin
         step(vt[i].wen, vt[i].waddr, vt[i].wdata, vt[i].wbe, vt[i].rcs, vt[i].raddr);
         check("vec_rvalid", {31'b0, if0.RVALID}, {31'b0, vt[i].exp_rv});
         check("vec_rdata", if0.RDATA, vt[i].exp_rd);
      end

      // Back-to-back reads through the two-stage pipeline.
      for (int a = 0; a < 4; a++) step(1'b1, 4'(a), 32'h10 + 32'(a), 4'hF, 1'b0, 4'd0);
      for (int j = 0; j < 6; j++) begin
         if (j < 4) step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(j));
         else       idle();
         check("lat2_rvalid", {31'b0, if1.RVALID}, {31'b0, exp_rv2[j]});
         if (j > 0) check("lat2_rdata", if1.RDATA, exp_d2[j]);
      end

      // Randomised traffic with frequent same-address collisions.
      for (int i = 0; i < 400; i++) begin
         wa = 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ra);
      end

      // Reset with a read in flight, then reset again part-way through the sweep.
      step(1'b1, 4'd3, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd0);
      step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
      check("inflight_pre_rst", if0.RDATA, 32'hCAFE_F00D);
      reset_a(2);
      for (int i = 0; i < 7; i++) step(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd2);
      reset_a(1);
      count_busy(1'b1, n);
      check("busy_len_restart", 32'(n), 32'd16);
      step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
      check("wr_in_busy_rvalid", {31'b0, if0.RVALID}, 32'd1);
      check("wr_in_busy_rdata", if0.RDATA, 32'd0);
      idle();
      idle();

      // No sweep: contents survive a reset pulse.
      check("nz_busy", {31'b0, if2.BUSY}, 32'd0);
      if2.WEN = 1'b1; if2.WADDR = 4'd9; if2.WDATA = 32'h5A5A_5A5A; if2.WBE = 4'hF;
      @(posedge CK); #1; cyc++;
      if2.WEN = 1'b0;
      rst_b = 1'b1;
      #1;
      check("nz_rst_rvalid", {31'b0, if2.RVALID}, 32'd0);
      check("nz_rst_busy", {31'b0, if2.BUSY}, 32'd0);
      @(posedge CK); #1; cyc++;
      rst_b = 1'b0;
      if2.RCS = 1'b1; if2.RADDR = 4'd9;
      @(posedge CK); #1; cyc++;
      if2.RCS = 1'b0;
      check("nz_busy_after", {31'b0, if2.BUSY}, 32'd0);
      check("nz_rvalid", {31'b0, if2.RVALID}, 32'd1);
      check("nz_rdata", if2.RDATA, 32'h5A5A_5A5A);
      @(posedge CK); #1; cyc++;
      check("nz_rvalid_off", {31'b0, if2.RVALID}, 32'd0);
      check("nz_rdata_hold", if2.RDATA, 32'h5A5A_5A5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
